// File: rtl/mem_write_buffer_pkg.sv
// Shared widths and types for the posted-write buffer.
package mem_write_buffer_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_BUS,
    RESP
  } rd_state_t;

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// Circular write FIFO; the head stays in the queue until its bus ack.
// MEM_WRITE_BUFFER_FWD_EN adds oldest-first entry/valid views.
module wb_fifo
  import mem_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        push_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
`ifdef MEM_WRITE_BUFFER_FWD_EN
  ,
  output wb_entry_t        ent_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
`endif
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO may still take a push when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifdef MEM_WRITE_BUFFER_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_o[i] = mem_q[rd_ptr_q + PW'(i)];
      vld_o[i] = CW'(i) < count_q;
    end
  end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer and memory-bus sequencer behind the cache.
// Define MEM_WRITE_BUFFER_FWD_EN to serve reads from queued writes.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = mem_write_buffer_pkg::ADDR_W,
  parameter  int DATA_W = mem_write_buffer_pkg::DATA_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_read_en,
  input  logic              req_write_en,
  output logic [DATA_W-1:0] req_rdata,
  output logic              req_ready,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [CW-1:0]     fifo_count
);

  rd_state_t         state_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] rd_addr_q;

  wb_entry_t         head;
  wb_entry_t         push_ent;
  logic              full;
  logic              empty;
  logic              pop;
  logic              accept;
  logic              rd_take;
  logic              wr_take;
  logic              rd_bus;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

`ifdef MEM_WRITE_BUFFER_FWD_EN
  wb_entry_t         ent [DEPTH];
  logic [DEPTH-1:0]  vld;
`endif

  assign push_ent = '{addr: req_addr, data: req_wdata};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (wr_take),
    .push_data_i(push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (fifo_count)
`ifdef MEM_WRITE_BUFFER_FWD_EN
    ,
    .ent_o      (ent),
    .vld_o      (vld)
`endif
  );

  // A read only owns the bus once the FIFO has fully drained.
  assign rd_bus  = state_q == RD_BUS;
  assign drain   = !empty && !rd_bus;
  assign pop     = drain && bus_ack;

  assign accept  = (state_q == IDLE) && !ready_q;
  assign rd_take = accept && req_read_en;
  assign wr_take = accept && !req_read_en && req_write_en
                   && (!full || pop);

`ifdef MEM_WRITE_BUFFER_FWD_EN
  // Oldest-first scan, so the last hit is the youngest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && ent[i].addr == req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = ent[i].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd_take && fwd_hit) begin
            rdata_q <= fwd_data;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else if (rd_take) begin
            rd_addr_q <= req_addr;
            state_q   <= RD_WAIT;
          end else if (wr_take) begin
            ready_q <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (fifo_count == '0) state_q <= RD_BUS;
        end
        RD_BUS: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            ready_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign req_rdata = rdata_q;
  assign bus_valid = rd_bus || drain;
  assign bus_we    = drain;
  assign bus_addr  = rd_bus ? rd_addr_q
                   : (drain ? head.addr : '0);
  assign bus_wdata = drain ? head.data : '0;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: queue-based model plus directed cases.
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_read_en = 1'b0;
  logic          req_write_en = 1'b0;
  logic [31:0]   req_rdata;
  logic          req_ready;
  logic          bus_valid;
  logic          bus_we;
  logic [15:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack = 1'b0;
  logic [31:0]   bus_rdata = '0;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_read_en (req_read_en),
    .req_write_en(req_write_en),
    .req_rdata   (req_rdata),
    .req_ready   (req_ready),
    .bus_valid   (bus_valid),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .fifo_count  (fifo_count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: queued writes in order, plus an outstanding-read flag pair.
  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ment_t;

  ment_t       mq[$];
  bit          m_ready = 0;
  bit          rd_out = 0;
  bit          rd_granted = 0;
  logic [31:0] m_rdata = '0;
  logic [15:0] rd_a = '0;

  always @(posedge clk) begin
    bit drain, pop, acc, nrdy, hit, psh;
    ment_t e;
    if (reset) begin
      mq.delete();
      m_ready = 0;
      rd_out = 0;
      rd_granted = 0;
      m_rdata = '0;
    end else begin
      drain = mq.size() != 0 && !rd_granted;
      pop = drain && bus_ack;
      acc = !rd_out && !m_ready;
      nrdy = 0;
      hit = 0;
      psh = 0;
      if (rd_granted) begin
        if (bus_ack) begin
          m_rdata = bus_rdata;
          nrdy = 1;
          rd_out = 0;
          rd_granted = 0;
        end
      end else if (rd_out && mq.size() == 0) begin
        rd_granted = 1;
      end
      if (acc && req_read_en) begin
`ifdef MEM_WRITE_BUFFER_FWD_EN
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].a == req_addr) begin
            hit = 1;
            m_rdata = mq[i].d;
          end
        end
`endif
        if (hit) nrdy = 1;
        else begin
          rd_out = 1;
          rd_a = req_addr;
        end
      end else if (acc && req_write_en
                   && (mq.size() < DEPTH || pop)) begin
        psh = 1;
        nrdy = 1;
      end
      if (pop) void'(mq.pop_front());
      if (psh) begin
        e.a = req_addr;
        e.d = req_wdata;
        mq.push_back(e);
      end
      m_ready = nrdy;
    end
  end

  always @(negedge clk) begin
    chk("count", fifo_count, mq.size());
    chk("ready", req_ready, m_ready);
    chk("rdata", req_rdata, m_rdata);
    chk("valid", bus_valid, rd_granted || mq.size() != 0);
    if (rd_granted) begin
      chk("rd_we", bus_we, 0);
      chk("rd_addr", bus_addr, rd_a);
    end else if (mq.size() != 0) begin
      chk("wr_we", bus_we, 1);
      chk("wr_addr", bus_addr, mq[0].a);
      chk("wr_data", bus_wdata, mq[0].d);
    end
  end

  // Bus handshake log {we, addr} and ready pulse counter.
  logic [16:0] hs[$];
  int          n_ready = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_valid && bus_ack) hs.push_back({bus_we, bus_addr});
      if (req_ready) n_ready++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(input bit rd, input bit wr,
                        input logic [15:0] a, input logic [31:0] d,
                        output int lat);
    req_addr = a;
    req_wdata = d;
    req_read_en = rd;
    req_write_en = wr;
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      step();
      if (req_ready) begin
        lat = n;
        break;
      end
    end
    step();
    req_read_en = 0;
    req_write_en = 0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: no req_ready for addr %0h", a);
    end
  endtask

  task automatic wait_empty(input string nm);
    int n;
    for (n = 0; n < 40; n++) begin
      if (fifo_count == 0) break;
      step();
    end
    chk(nm, fifo_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int lat, hs0, nr0, c0, n60;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_count", fifo_count, 0);
    reset = 0;

    // single write, idle bus
    req_addr = 16'h0010;
    req_wdata = 32'hDEADBEEF;
    req_write_en = 1;
    step();
    chk("t1_ready", req_ready, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_valid", bus_valid, 1);
    chk("t1_we", bus_we, 1);
    chk("t1_addr", bus_addr, 16'h0010);
    chk("t1_wdata", bus_wdata, 32'hDEADBEEF);
    req_write_en = 0;
    bus_ack = 1;
    step();
    chk("t1_pulse", req_ready, 0);
    chk("t1_count0", fifo_count, 0);
    chk("t1_valid0", bus_valid, 0);
    bus_ack = 0;

    // fill to DEPTH with bus stalled, fifth waits for a slot
    hs0 = hs.size();
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1, 16'h0100 + 16'(i), 32'h11111111 * (i + 1), lat);
      chk("t2_lat", lat, 1);
    end
    chk("t2_full", fifo_count, 4);
    req_addr = 16'h0104;
    req_wdata = 32'h55555555;
    req_write_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall", req_ready, 0);
    end
    bus_ack = 1;
    step();
    chk("t2_fifth", req_ready, 1);
    chk("t2_cnt", fifo_count, 4);
    chk("t2_head", bus_addr, 16'h0101);
    req_write_en = 0;
    wait_empty("t2_drain");
    bus_ack = 0;
    for (int i = 0; i < 5; i++)
      chk("t2_order", hs[hs0 + i], {1'b1, 16'h0100 + 16'(i)});

    // read behind two queued writes
    hs0 = hs.size();
    do_req(0, 1, 16'h0020, 32'hA0A0A0A0, lat);
    do_req(0, 1, 16'h0021, 32'hA1A1A1A1, lat);
    chk("t3_cnt", fifo_count, 2);
    bus_rdata = 32'h12345678;
    bus_ack = 1;
    nr0 = n_ready;
    do_req(1, 0, 16'h0030, 32'h0, lat);
    bus_ack = 0;
    chk("t3_rdata", req_rdata, 32'h12345678);
    chk("t3_pulses", n_ready - nr0, 1);
    chk("t3_nhs", hs.size() - hs0, 3);
    chk("t3_hs0", hs[hs0], {1'b1, 16'h0020});
    chk("t3_hs1", hs[hs0 + 1], {1'b1, 16'h0021});
    chk("t3_hs2", hs[hs0 + 2], {1'b0, 16'h0030});

`ifdef MEM_WRITE_BUFFER_FWD_EN
    // forwarding from the youngest matching write
    do_req(0, 1, 16'h0040, 32'h1, lat);
    do_req(0, 1, 16'h0040, 32'h2, lat);
    hs0 = hs.size();
    do_req(1, 0, 16'h0040, 32'h0, lat);
    chk("t4_lat", lat, 1);
    chk("t4_rdata", req_rdata, 32'h2);
    chk("t4_nobus", hs.size() - hs0, 0);
    bus_ack = 1;
    wait_empty("t4_drain");
    bus_ack = 0;
`endif

    // both enables high: read only, held through ready
    bus_rdata = 32'hCAFEF00D;
    bus_ack = 1;
    c0 = fifo_count;
    hs0 = hs.size();
    do_req(1, 1, 16'h0050, 32'h55555555, lat);
    step();
    bus_ack = 0;
    chk("t5_lat", lat, 3);
    chk("t5_rdata", req_rdata, 32'hCAFEF00D);
    chk("t5_cnt", fifo_count, c0);
    chk("t5_nhs", hs.size() - hs0, 1);
    chk("t5_hs", hs[hs0], {1'b0, 16'h0050});

    // reset while the read owns the bus
    for (int i = 0; i < 3; i++)
      do_req(0, 1, 16'h0070 + 16'(i), 32'h70 + i, lat);
    chk("t6_cnt", fifo_count, 3);
    req_addr = 16'h0060;
    req_read_en = 1;
    step();
    req_read_en = 0;
    bus_ack = 1;
    wait_empty("t6_drain");
    bus_ack = 0;
    step();
    chk("t6_rdbus_v", bus_valid, 1);
    chk("t6_rdbus_we", bus_we, 0);
    chk("t6_rdbus_a", bus_addr, 16'h0060);
    reset = 1;
    bus_ack = 1;
    step();
    chk("t6_ready", req_ready, 0);
    chk("t6_rdata", req_rdata, 0);
    chk("t6_valid", bus_valid, 0);
    chk("t6_we", bus_we, 0);
    chk("t6_addr", bus_addr, 0);
    chk("t6_wdata", bus_wdata, 0);
    chk("t6_count", fifo_count, 0);
    reset = 0;
    step();
    chk("t6_idle_v", bus_valid, 0);
    chk("t6_idle_r", req_ready, 0);
    bus_ack = 0;
    n60 = 0;
    foreach (hs[i]) if (hs[i] == {1'b0, 16'h0060}) n60++;
    chk("t6_no_read", n60, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
